grid_loader: RTL and testbench
==============================

GRID_LOADER -- requirements
Module: grid_loader

Interface
REQ-001 Parameter WIDTH, default 8: grid columns, one row per transfer.
REQ-002 Parameter HEIGHT, default 8: grid rows; memory word width DATA_SIZE = WIDTH*HEIGHT.
REQ-003 Parameter STEP_CYCLES, default 4, legal >= 1: clock cycles per generation in run mode.
REQ-004 Parameter GEN_WIDTH, default 16: generation counter width.
REQ-005 clk  in  1  system clock; sole clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start_load  in  1  request to begin loading a new initial grid.
REQ-008 run_enable  in  1  level: permit/continue generation stepping.
REQ-009 row_data  in  WIDTH  one grid row from external source.
REQ-010 row_valid  in  1  row_data valid.
REQ-011 row_ready  out  1  loader accepts row this cycle.
REQ-012 initial_out  out  WIDTH*HEIGHT  assembled grid; drives the system memory initial_in.
REQ-013 write_enable  out  1  system memory write enable.
REQ-014 load_run  out  1  system memory source select: 0 = initial_out, 1 = grid calculator.
REQ-015 busy  out  1  high whenever state is not IDLE.
REQ-016 generation  out  GEN_WIDTH  generations written since last commit.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, COMMIT, RUN.
REQ-018 IDLE: row_ready=0, write_enable=0, load_run=0; start_load=1 -> LOAD; else start_load=0 and run_enable=1 -> RUN; else stay.
REQ-019 On IDLE->LOAD or RUN->LOAD, row counter SHALL clear to 0 and internal row buffer SHALL clear to all zeros.
REQ-020 LOAD: row_ready=1; start_load ignored; run_enable ignored.
REQ-021 Row transfer SHALL occur only on cycles with row_valid=1 and row_ready=1; row k (k-th accepted, from 0) SHALL be stored at buffer bits [k*WIDTH+WIDTH-1 : k*WIDTH].
REQ-022 Each transfer SHALL increment the row counter; transfer of row HEIGHT-1 SHALL move FSM to COMMIT on the next edge; row_valid=0 cycles SHALL stall without loss.
REQ-023 initial_out SHALL be registered and updated from the buffer on entry to COMMIT; it SHALL hold that value until the next COMMIT or reset.
REQ-024 COMMIT lasts exactly one cycle: write_enable=1, load_run=0, row_ready=0; generation SHALL clear to 0 at the end of this cycle.
REQ-025 COMMIT exit: run_enable=1 -> RUN, else -> IDLE.
REQ-026 RUN: load_run=1, row_ready=0; step timer loaded with STEP_CYCLES-1 on RUN entry, decrements each RUN cycle.
REQ-027 In RUN, write_enable SHALL be 1 exactly in cycles where timer==0 and run_enable=1; in that cycle timer SHALL reload STEP_CYCLES-1 and generation SHALL increment by 1 mod 2^GEN_WIDTH.
REQ-028 First RUN write pulse SHALL occur in the STEP_CYCLES-th RUN cycle; STEP_CYCLES=1 gives a pulse every RUN cycle.
REQ-029 RUN with run_enable=0 SHALL produce no write pulse that cycle and move to IDLE; generation holds.
REQ-030 RUN with start_load=1 (priority over run_enable) SHALL suppress the write pulse and move to LOAD; generation holds until next COMMIT.
REQ-031 write_enable and row_ready SHALL be derived only from state, timer and run_enable; never from row_valid.
REQ-032 busy SHALL be 0 only in IDLE.

Reset
REQ-033 reset=1 at a rising edge SHALL, regardless of state: state IDLE, row counter 0, buffer 0, initial_out 0, timer STEP_CYCLES-1, generation 0.
REQ-034 During and after reset cycle: row_ready=0, write_enable=0, load_run=0, busy=0; reset mid-LOAD SHALL discard partial rows.

Verification (WIDTH=4, HEIGHT=3, STEP_CYCLES=3)
REQ-035 Load: start_load, rows 0x1,0x2,0x4 back-to-back with run_enable=0 -> initial_out=0x421, one-cycle write_enable with load_run=0, return to IDLE, busy low.
REQ-036 Stall: same rows with row_valid low 2 cycles between each -> identical initial_out 0x421, exactly 3 transfers, one COMMIT pulse.
REQ-037 Run: after load, run_enable=1 held 10 cycles -> load_run=1, write_enable pulses in RUN cycles 3,6,9, generation=3.
REQ-038 Stop/restart: run_enable dropped in a timer==0 cycle -> no pulse, IDLE next cycle, generation held; re-raise -> RUN, first pulse 3 cycles later.
REQ-039 Reset mid-LOAD after 2 rows -> all outputs zero; new load of 0xF,0x0,0xF -> initial_out=0xF0F.
REQ-040 Abort: start_load during RUN -> no write pulse, LOAD entered, row_ready=1 next cycle; commit resets generation to 0.

Source files
------------

// File: rtl/grid_loader.sv
// Grid loader: assembles HEIGHT rows of WIDTH bits into an initial grid, commits it
// to system memory, then paces generation writes every STEP_CYCLES clocks in run mode.
module grid_loader #(
    parameter int WIDTH       = 8,
    parameter int HEIGHT      = 8,
    parameter int STEP_CYCLES = 4,
    parameter int GEN_WIDTH   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_load,
    input  logic                    run_enable,
    input  logic [WIDTH-1:0]        row_data,
    input  logic                    row_valid,
    output logic                    row_ready,
    output logic [WIDTH*HEIGHT-1:0] initial_out,
    output logic                    write_enable,
    output logic                    load_run,
    output logic                    busy,
    output logic [GEN_WIDTH-1:0]    generation
);

    localparam int DATA_SIZE = WIDTH * HEIGHT;
    localparam int ROW_W     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int TMR_W     = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(HEIGHT - 1);
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_COMMIT,
        S_RUN
    } state_e;

    state_e                 state_q, state_d;
    logic [ROW_W-1:0]       row_cnt_q, row_cnt_d;
    logic [DATA_SIZE-1:0]   buf_q, buf_d;
    logic [DATA_SIZE-1:0]   init_q, init_d;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic [GEN_WIDTH-1:0]   gen_q, gen_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            row_cnt_q <= '0;
            buf_q     <= '0;
            init_q    <= '0;
            timer_q   <= TMR_RELOAD;
            gen_q     <= '0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            buf_q     <= buf_d;
            init_q    <= init_d;
            timer_q   <= timer_d;
            gen_q     <= gen_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        row_cnt_d    = row_cnt_q;
        buf_d        = buf_q;
        init_d       = init_q;
        timer_d      = timer_q;
        gen_d        = gen_q;
        row_ready    = 1'b0;
        write_enable = 1'b0;
        load_run     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_load) begin
                    state_d   = S_LOAD;
                    row_cnt_d = '0;
                    buf_d     = '0;
                end else if (run_enable) begin
                    state_d = S_RUN;
                    timer_d = TMR_RELOAD;
                end
            end
            S_LOAD: begin
                row_ready = 1'b1;
                if (row_valid) begin
                    for (int unsigned r = 0; r < HEIGHT; r++) begin
                        if (row_cnt_q == ROW_W'(r)) begin
                            buf_d[r*WIDTH +: WIDTH] = row_data;
                        end
                    end
                    row_cnt_d = row_cnt_q + ROW_W'(1);
                    // Snapshot includes the row arriving this cycle.
                    if (row_cnt_q == LAST_ROW) begin
                        state_d = S_COMMIT;
                        init_d  = buf_d;
                    end
                end
            end
            S_COMMIT: begin
                write_enable = 1'b1;
                gen_d        = '0;
                if (run_enable) begin
                    state_d = S_RUN;
                    timer_d = TMR_RELOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                load_run = 1'b1;
                if (start_load) begin
                    state_d   = S_LOAD;
                    row_cnt_d = '0;
                    buf_d     = '0;
                end else if (!run_enable) begin
                    state_d = S_IDLE;
                end else if (timer_q == '0) begin
                    write_enable = 1'b1;
                    timer_d      = TMR_RELOAD;
                    gen_d        = gen_q + GEN_WIDTH'(1);
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy        = (state_q != S_IDLE);
    assign initial_out = init_q;
    assign generation  = gen_q;

endmodule

// File: tb/tb_grid_loader.sv
// Bench for grid_loader (WIDTH=4, HEIGHT=3, STEP_CYCLES=3): per-cycle vector table
// plus a scoreboard of committed grids built from the driven rows.
module tb_grid_loader;

    localparam int W = 4;
    localparam int H = 3;
    localparam int S = 3;
    localparam int G = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic           start_load;
    logic           run_enable;
    logic [W-1:0]   row_data;
    logic           row_valid;
    logic           row_ready;
    logic [W*H-1:0] initial_out;
    logic           write_enable;
    logic           load_run;
    logic           busy;
    logic [G-1:0]   generation;

    grid_loader #(
        .WIDTH      (W),
        .HEIGHT     (H),
        .STEP_CYCLES(S),
        .GEN_WIDTH  (G)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start_load  (start_load),
        .run_enable  (run_enable),
        .row_data    (row_data),
        .row_valid   (row_valid),
        .row_ready   (row_ready),
        .initial_out (initial_out),
        .write_enable(write_enable),
        .load_run    (load_run),
        .busy        (busy),
        .generation  (generation)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        start;
        logic        run;
        logic        rv;
        logic [3:0]  rd;
        logic        rr;
        logic        we;
        logic        lr;
        logic        busy;
        logic [11:0] init;
        logic [15:0] gen;
    } vec_t;

    vec_t        vecs[$];
    logic [11:0] sb_q[$];
    int          errors = 0;
    int          checks = 0;
    int          handshakes = 0;

    task automatic add(input logic rst, input logic start, input logic run, input logic rv,
                       input logic [3:0] rd, input logic rr, input logic we, input logic lr,
                       input logic bsy, input logic [11:0] init, input logic [15:0] gen);
        vec_t v;
        v.rst = rst; v.start = start; v.run = run; v.rv = rv; v.rd = rd;
        v.rr = rr; v.we = we; v.lr = lr; v.busy = bsy; v.init = init; v.gen = gen;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic [11:0] acc;
        logic [11:0] exp_grid;
        int          nrows;
        acc   = '0;
        nrows = 0;

        // rst start run rv rd | rr we lr busy init gen
        add(0,0,0,0,4'h0, 0,0,0,0,12'h000,16'd0);          // post-reset state
        // back-to-back load, run_enable low
        add(0,1,0,0,4'h0, 0,0,0,0,12'h000,16'd0);
        add(0,0,0,1,4'h1, 1,0,0,1,12'h000,16'd0);
        add(0,0,0,1,4'h2, 1,0,0,1,12'h000,16'd0);
        add(0,0,0,1,4'h4, 1,0,0,1,12'h000,16'd0);
        add(0,0,0,0,4'h0, 0,1,0,1,12'h421,16'd0);          // COMMIT
        add(0,0,0,0,4'h0, 0,0,0,0,12'h421,16'd0);
        // stalled load, junk on row_data while row_valid low
        add(0,1,0,0,4'h0, 0,0,0,0,12'h421,16'd0);
        add(0,0,0,1,4'h1, 1,0,0,1,12'h421,16'd0);
        add(0,0,0,0,4'hF, 1,0,0,1,12'h421,16'd0);
        add(0,0,0,0,4'hF, 1,0,0,1,12'h421,16'd0);
        add(0,0,0,1,4'h2, 1,0,0,1,12'h421,16'd0);
        add(0,0,0,0,4'hF, 1,0,0,1,12'h421,16'd0);
        add(0,0,0,0,4'hF, 1,0,0,1,12'h421,16'd0);
        add(0,0,0,1,4'h4, 1,0,0,1,12'h421,16'd0);
        add(0,0,0,0,4'h0, 0,1,0,1,12'h421,16'd0);
        add(0,0,0,0,4'h0, 0,0,0,0,12'h421,16'd0);
        // run: IDLE cycle then RUN cycles 1..10, pulses at 3, 6, 9
        add(0,0,1,0,4'h0, 0,0,0,0,12'h421,16'd0);
        for (int k = 1; k <= 10; k++)
            add(0,0,1,0,4'h0, 0,(k % 3 == 0),1,1,12'h421,16'((k - 1) / 3));
        add(0,0,1,0,4'h0, 0,0,1,1,12'h421,16'd3);          // RUN 11, timer 1
        add(0,0,0,0,4'h0, 0,0,1,1,12'h421,16'd3);          // RUN 12, timer 0, stop
        add(0,0,0,0,4'h0, 0,0,0,0,12'h421,16'd3);
        add(0,0,1,0,4'h0, 0,0,0,0,12'h421,16'd3);          // restart
        add(0,0,1,0,4'h0, 0,0,1,1,12'h421,16'd3);
        add(0,0,1,0,4'h0, 0,0,1,1,12'h421,16'd3);
        add(0,0,1,0,4'h0, 0,1,1,1,12'h421,16'd3);
        add(0,0,1,0,4'h0, 0,0,1,1,12'h421,16'd4);
        add(0,0,1,0,4'h0, 0,0,1,1,12'h421,16'd4);
        add(0,1,1,0,4'h0, 0,0,1,1,12'h421,16'd4);          // abort at timer 0
        add(0,0,1,0,4'h0, 1,0,0,1,12'h421,16'd4);
        add(0,1,1,1,4'h3, 1,0,0,1,12'h421,16'd4);          // start ignored in LOAD
        add(0,0,1,1,4'h5, 1,0,0,1,12'h421,16'd4);
        add(0,0,1,1,4'h6, 1,0,0,1,12'h421,16'd4);
        add(0,0,1,0,4'h0, 0,1,0,1,12'h653,16'd4);          // COMMIT -> RUN
        add(0,0,1,0,4'h0, 0,0,1,1,12'h653,16'd0);
        add(0,0,0,0,4'h0, 0,0,1,1,12'h653,16'd0);
        add(0,0,0,0,4'h0, 0,0,0,0,12'h653,16'd0);
        // reset in the middle of a load
        add(0,1,0,0,4'h0, 0,0,0,0,12'h653,16'd0);
        add(0,0,0,1,4'h9, 1,0,0,1,12'h653,16'd0);
        add(0,0,0,1,4'h6, 1,0,0,1,12'h653,16'd0);
        add(1,0,0,1,4'h7, 1,0,0,1,12'h653,16'd0);
        add(0,0,0,0,4'h0, 0,0,0,0,12'h000,16'd0);
        add(0,1,0,0,4'h0, 0,0,0,0,12'h000,16'd0);
        add(0,0,0,1,4'hF, 1,0,0,1,12'h000,16'd0);
        add(0,0,0,1,4'h0, 1,0,0,1,12'h000,16'd0);
        add(0,0,0,1,4'hF, 1,0,0,1,12'h000,16'd0);
        add(0,0,0,0,4'h0, 0,1,0,1,12'hF0F,16'd0);
        add(0,0,0,0,4'h0, 0,0,0,0,12'hF0F,16'd0);

        reset      = 1'b1;
        start_load = 1'b0;
        run_enable = 1'b0;
        row_valid  = 1'b0;
        row_data   = '0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset      = vecs[i].rst;
            start_load = vecs[i].start;
            run_enable = vecs[i].run;
            row_valid  = vecs[i].rv;
            row_data   = vecs[i].rd;
            #1;
            check($sformatf("vec%0d", i),
                  {row_ready, write_enable, load_run, busy, initial_out, generation},
                  {vecs[i].rr, vecs[i].we, vecs[i].lr, vecs[i].busy, vecs[i].init, vecs[i].gen});

            if (row_valid && row_ready && !reset) handshakes++;

            if (vecs[i].rst) begin
                acc   = '0;
                nrows = 0;
            end else begin
                if (vecs[i].start && !vecs[i].rr) begin
                    acc   = '0;
                    nrows = 0;
                end
                if (vecs[i].rv && vecs[i].rr) begin
                    acc = acc | (12'(vecs[i].rd) << (nrows * W));
                    nrows++;
                    if (nrows == H) begin
                        sb_q.push_back(acc);
                        acc   = '0;
                        nrows = 0;
                    end
                end
            end

            if (write_enable && !load_run) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_commit vec%0d: got commit of %h expected no commit", i, initial_out);
                end else begin
                    exp_grid = sb_q.pop_front();
                    check($sformatf("sb_commit_vec%0d", i), 32'(initial_out), 32'(exp_grid));
                end
            end
        end

        @(negedge clk);
        reset      = 1'b0;
        start_load = 1'b0;
        run_enable = 1'b0;
        row_valid  = 1'b0;
        check("handshakes", 32'(handshakes), 32'd14);
        check("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
